// File: rtl/fpmul_arb_if.sv
// Bus bundle between the two requesters, the arbiter and the shared fpmul.
// Both requesters and the fpmul sit on the master side; the arbiter uses the slave side.
interface fpmul_arb_if #(parameter int unsigned W = 16);
    logic         req0;
    logic         req1;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic         ack0;
    logic         ack1;
    logic [W-1:0] res;
    logic         err;
    logic         busy;
    logic         mul_en;
    logic [W-1:0] mul_x1;
    logic [W-1:0] mul_x2;
    logic         mul_rst;
    logic [W-1:0] mul_y;
    logic         mul_ready;

    modport slave (
        input  req0, req1, a0, b0, a1, b1, mul_y, mul_ready,
        output ack0, ack1, res, err, busy, mul_en, mul_x1, mul_x2, mul_rst
    );

    modport master (
        output req0, req1, a0, b0, a1, b1, mul_y, mul_ready,
        input  ack0, ack1, res, err, busy, mul_en, mul_x1, mul_x2, mul_rst
    );
endinterface

// File: rtl/fpmul_arb.sv
// Round-robin arbiter sharing one multi-cycle fpmul between two requesters,
// with a ready timeout that aborts the fpmul and returns an error result.
module fpmul_arb #(
    parameter int unsigned W       = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst,
    fpmul_arb_if.slave     bus
);
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t         state_q, state_d;
    logic           grant_q, grant_d;
    logic           last_q, last_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   x1_q, x1_d;
    logic [W-1:0]   x2_q, x2_d;
    logic [W-1:0]   res_q, res_d;
    logic           err_q, err_d;
    logic           ack0_q, ack0_d;
    logic           ack1_q, ack1_d;
    logic           mul_en_q, mul_en_d;
    logic           busy_q, busy_d;
    logic           mul_rst_q, mul_rst_d;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        x1_d      = x1_q;
        x2_d      = x2_q;
        res_d     = res_q;
        err_d     = err_q;
        mul_rst_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_d = ISSUE;
                    // On a tie, serve whoever was not served last
                    grant_d = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
                    x1_d    = grant_d ? bus.a1 : bus.a0;
                    x2_d    = grant_d ? bus.b1 : bus.b0;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (bus.mul_ready) begin
                    res_d   = bus.mul_y;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == CW'(TIMEOUT - 1)) begin
                        res_d     = '0;
                        err_d     = 1'b1;
                        mul_rst_d = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        mul_en_d = (state_d == ISSUE);
        busy_d   = (state_d != IDLE);
        ack0_d   = (state_d == DONE) && !grant_d;
        ack1_d   = (state_d == DONE) &&  grant_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            x1_q      <= '0;
            x2_q      <= '0;
            res_q     <= '0;
            err_q     <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            mul_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            mul_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            x1_q      <= x1_d;
            x2_q      <= x2_d;
            res_q     <= res_d;
            err_q     <= err_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            mul_en_q  <= mul_en_d;
            busy_q    <= busy_d;
            mul_rst_q <= mul_rst_d;
        end
    end

    assign bus.ack0    = ack0_q;
    assign bus.ack1    = ack1_q;
    assign bus.res     = res_q;
    assign bus.err     = err_q;
    assign bus.busy    = busy_q;
    assign bus.mul_en  = mul_en_q;
    assign bus.mul_x1  = x1_q;
    assign bus.mul_x2  = x2_q;
    assign bus.mul_rst = mul_rst_q;
endmodule

// File: tb/tb_fpmul_arb.sv
// Bench for fpmul_arb: behavioural bfloat16 fpmul with configurable latency,
// directed scenarios plus randomized traffic against a round-robin reference.
module tb_fpmul_arb;
    localparam int unsigned W       = 16;
    localparam int unsigned TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   en_cyc   = 0;
    int   en_cnt   = 0;
    int   mrst_cnt = 0;
    int   lat      = 3;
    bit   never    = 1'b0;
    int   m_cnt    = 0;

    fpmul_arb_if #(.W(W)) bus ();

    fpmul_arb #(.W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference bfloat16 product (truncating, normal operands and zero only)
    function automatic logic [15:0] bf16_mul(input logic [15:0] x, input logic [15:0] y);
        logic        s;
        logic [15:0] p;
        int          e;
        s = x[15] ^ y[15];
        if (x[14:7] == 8'd0 || y[14:7] == 8'd0) return {s, 15'd0};
        p = {8'd0, 1'b1, x[6:0]} * {8'd0, 1'b1, y[6:0]};
        e = int'(x[14:7]) + int'(y[14:7]) - 127;
        if (p[15]) begin
            e++;
            return {s, 8'(e), p[14:8]};
        end
        return {s, 8'(e), p[13:7]};
    endfunction

    function automatic logic [15:0] rnd_op();
        logic [15:0] v;
        v = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 7'($urandom)};
        return v;
    endfunction

    // Behavioural fpmul: ready rises L cycles after the en cycle and stays high until next en/rst
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mul_rst === 1'b1) begin
            m_cnt         <= 0;
            bus.mul_ready <= 1'b0;
        end else if (bus.mul_en === 1'b1) begin
            bus.mul_y     <= bf16_mul(bus.mul_x1, bus.mul_x2);
            m_cnt         <= lat - 1;
            bus.mul_ready <= (lat == 1) && !never;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1 && !never) bus.mul_ready <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (bus.mul_en === 1'b1) begin
            en_cnt <= en_cnt + 1;
            en_cyc <= cyc;
        end
        if (bus.mul_rst === 1'b1) mrst_cnt <= mrst_cnt + 1;
    end

    // Waits (bounded) for an ack; the acked requester drops its request
    task automatic wait_ack(output bit got, output bit w0, output bit w1, output int l,
                            output logic [15:0] r, output logic e);
        got = 1'b0; w0 = 1'b0; w1 = 1'b0; l = 0; r = '0; e = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) begin
                got = 1'b1;
                w0  = bus.ack0;
                w1  = bus.ack1;
                l   = cyc - en_cyc;
                r   = bus.res;
                e   = bus.err;
                if (w0) bus.req0 = 1'b0;
                if (w1) bus.req1 = 1'b0;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.ack0, bus.ack1, bus.mul_en, bus.err, bus.busy, bus.mul_rst, bus.res, bus.mul_x1, bus.mul_x2}
            !== {5'b0, 1'b1, 48'h0}) begin
            failures++;
            $display("FAIL reset_state got ack=%b%b en=%b err=%b busy=%b mrst=%b res=%h x=%h/%h",
                     bus.ack0, bus.ack1, bus.mul_en, bus.err, bus.busy, bus.mul_rst, bus.res, bus.mul_x1, bus.mul_x2);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.busy, bus.mul_en, bus.mul_rst} !== 3'b000) begin
            failures++;
            $display("FAIL idle_after_reset got busy/en/mrst=%b%b%b expected 000", bus.busy, bus.mul_en, bus.mul_rst);
        end
    endtask

    task automatic test_basic();
        bit got, w0, w1; int l; logic [15:0] r; logic e; int en0;
        lat = 3;
        en0 = en_cnt;
        bus.a0 = 16'h4040; bus.b0 = 16'h4000; bus.req0 = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.mul_en !== 1'b1 || bus.mul_x1 !== 16'h4040 || bus.mul_x2 !== 16'h4000) begin
            failures++;
            $display("FAIL basic_issue got en=%b x1=%h x2=%h expected 1 4040 4000", bus.mul_en, bus.mul_x1, bus.mul_x2);
        end
        bus.a0 = rnd_op(); bus.b0 = rnd_op();
        wait_ack(got, w0, w1, l, r, e);
        checks++;
        if (!got || !w0 || w1 || r !== 16'h40C0 || e !== 1'b0 || l != 4) begin
            failures++;
            $display("FAIL basic_ack got=%b ack=%b%b res=%h err=%b lat=%0d expected ack0 res=40c0 err=0 lat=4",
                     got, w0, w1, r, e, l);
        end
        @(negedge clk);
        checks++;
        if (en_cnt - en0 != 1 || bus.ack0 !== 1'b0 || bus.busy !== 1'b0 || bus.res !== 16'h40C0) begin
            failures++;
            $display("FAIL basic_after got ens=%0d ack0=%b busy=%b res=%h expected 1 0 0 40c0",
                     en_cnt - en0, bus.ack0, bus.busy, bus.res);
        end
    endtask

    task automatic test_tie();
        bit got, w0, w1; int l; logic [15:0] r; logic e;
        lat = $urandom_range(1, 10);
        @(negedge clk);
        rst = 1'b1;
        bus.a0 = 16'hC000; bus.b0 = 16'h4000; bus.a1 = 16'h4420; bus.b1 = 16'h4200;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_ack(got, w0, w1, l, r, e);
        checks++;
        if (!got || !w0 || w1 || r !== 16'hC080 || e !== 1'b0) begin
            failures++;
            $display("FAIL tie_first got=%b ack=%b%b res=%h err=%b expected ack0 res=c080", got, w0, w1, r, e);
        end
        wait_ack(got, w0, w1, l, r, e);
        checks++;
        if (!got || w0 || !w1 || r !== 16'h46A0 || l != lat + 1) begin
            failures++;
            $display("FAIL tie_second got=%b ack=%b%b res=%h lat=%0d expected ack1 res=46a0 lat=%0d",
                     got, w0, w1, r, l, lat + 1);
        end
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        wait_ack(got, w0, w1, l, r, e);
        checks++;
        if (!got || !w0 || w1 || r !== 16'hC080) begin
            failures++;
            $display("FAIL tie_again got=%b ack=%b%b res=%h expected ack0 res=c080", got, w0, w1, r);
        end
        wait_ack(got, w0, w1, l, r, e);
    endtask

    task automatic test_alternate();
        bit got, w0, w1; int l; logic [15:0] r; logic e; logic [15:0] xa [2]; logic [15:0] xb [2];
        int bad = 0; int exp_w;
        lat = $urandom_range(1, 10);
        xa[0] = rnd_op(); xb[0] = rnd_op(); xa[1] = rnd_op(); xb[1] = rnd_op();
        bus.a0 = xa[0]; bus.b0 = xb[0]; bus.a1 = xa[1]; bus.b1 = xb[1];
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            exp_w = i % 2;
            wait_ack(got, w0, w1, l, r, e);
            if (!got || w0 != (exp_w == 0) || w1 != (exp_w == 1) || r !== bf16_mul(xa[exp_w], xb[exp_w])) begin
                bad++;
                $display("FAIL alternate_grant_%0d got=%b ack=%b%b res=%h expected ack%0d res=%h",
                         i, got, w0, w1, r, exp_w, bf16_mul(xa[exp_w], xb[exp_w]));
            end
            @(negedge clk);
            if (i < 5) begin
                xa[exp_w] = rnd_op(); xb[exp_w] = rnd_op();
                if (exp_w == 0) begin bus.a0 = xa[0]; bus.b0 = xb[0]; bus.req0 = 1'b1; end
                else            begin bus.a1 = xa[1]; bus.b1 = xb[1]; bus.req1 = 1'b1; end
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL alternate_sequence got %0d wrong grants expected 0", bad);
        end
    endtask

    task automatic test_timeout();
        bit got, w0, w1; int l; logic [15:0] r; logic e; int m0; logic [15:0] xa, xb;
        never = 1'b1;
        m0 = mrst_cnt;
        bus.a0 = rnd_op(); bus.b0 = rnd_op(); bus.req0 = 1'b1;
        wait_ack(got, w0, w1, l, r, e);
        checks++;
        if (!got || !w0 || r !== 16'h0000 || e !== 1'b1 || l != int'(TIMEOUT) || bus.mul_rst !== 1'b1) begin
            failures++;
            $display("FAIL timeout_ack got=%b ack0=%b res=%h err=%b lat=%0d mrst=%b expected res=0000 err=1 lat=%0d mrst=1",
                     got, w0, r, e, l, bus.mul_rst, TIMEOUT);
        end
        @(negedge clk);
        checks++;
        if (mrst_cnt - m0 != 1 || bus.err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_mrst got pulses=%0d err=%b expected 1 pulse err held 1", mrst_cnt - m0, bus.err);
        end
        never = 1'b0;
        lat = $urandom_range(1, 10);
        xa = rnd_op(); xb = rnd_op();
        bus.a1 = xa; bus.b1 = xb; bus.req1 = 1'b1;
        wait_ack(got, w0, w1, l, r, e);
        checks++;
        if (!got || !w1 || r !== bf16_mul(xa, xb) || e !== 1'b0 || l != lat + 1) begin
            failures++;
            $display("FAIL timeout_recover got=%b ack1=%b res=%h err=%b lat=%0d expected res=%h err=0 lat=%0d",
                     got, w1, r, e, l, bf16_mul(xa, xb), lat + 1);
        end
    endtask

    task automatic test_ready_wins();
        bit got, w0, w1; int l; logic [15:0] r; logic e; logic [15:0] xa, xb;
        lat = int'(TIMEOUT) - 1;
        xa = rnd_op(); xb = rnd_op();
        bus.a0 = xa; bus.b0 = xb; bus.req0 = 1'b1;
        wait_ack(got, w0, w1, l, r, e);
        checks++;
        if (!got || !w0 || r !== bf16_mul(xa, xb) || e !== 1'b0 || l != int'(TIMEOUT)) begin
            failures++;
            $display("FAIL ready_wins got=%b ack0=%b res=%h err=%b lat=%0d expected res=%h err=0 lat=%0d",
                     got, w0, r, e, l, bf16_mul(xa, xb), TIMEOUT);
        end
    endtask

    task automatic test_reset_mid();
        bit got, w0, w1; int l; logic [15:0] r; logic e; int acks = 0;
        lat = 10;
        bus.a0 = rnd_op(); bus.b0 = rnd_op(); bus.req0 = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        bus.req0 = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.ack0, bus.ack1, bus.mul_en, bus.err, bus.busy, bus.mul_rst, bus.res, bus.mul_x1, bus.mul_x2}
            !== {5'b0, 1'b1, 48'h0}) begin
            failures++;
            $display("FAIL midreset_state got ack=%b%b en=%b err=%b busy=%b mrst=%b res=%h x=%h/%h",
                     bus.ack0, bus.ack1, bus.mul_en, bus.err, bus.busy, bus.mul_rst, bus.res, bus.mul_x1, bus.mul_x2);
        end
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1 || bus.busy) acks++;
        end
        checks++;
        if (acks != 0) begin
            failures++;
            $display("FAIL midreset_no_ack got %0d cycles with ack/busy expected 0", acks);
        end
        lat = $urandom_range(1, 10);
        bus.a0 = 16'h0000; bus.b0 = 16'h4000; bus.req0 = 1'b1;
        wait_ack(got, w0, w1, l, r, e);
        checks++;
        if (!got || !w0 || w1 || r !== 16'h0000 || e !== 1'b0) begin
            failures++;
            $display("FAIL midreset_next got=%b ack=%b%b res=%h err=%b expected ack0 res=0000 err=0", got, w0, w1, r, e);
        end
    endtask

    task automatic test_random();
        bit got, w0, w1; int l; logic [15:0] r; logic e;
        bit pend [2]; logic [15:0] xa [2]; logic [15:0] xb [2];
        int last = 1; int exp_w; int bad = 0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            lat = $urandom_range(1, 10);
            for (int k = 0; k < 2; k++) begin
                if (!pend[k] && $urandom_range(0, 1) == 1) begin
                    pend[k] = 1'b1; xa[k] = rnd_op(); xb[k] = rnd_op();
                end
            end
            if (!pend[0] && !pend[1]) begin
                exp_w = $urandom_range(0, 1);
                pend[exp_w] = 1'b1; xa[exp_w] = rnd_op(); xb[exp_w] = rnd_op();
            end
            bus.a0 = xa[0]; bus.b0 = xb[0]; bus.a1 = xa[1]; bus.b1 = xb[1];
            bus.req0 = pend[0]; bus.req1 = pend[1];
            exp_w = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
            wait_ack(got, w0, w1, l, r, e);
            if (!got || w0 != (exp_w == 0) || w1 != (exp_w == 1) || r !== bf16_mul(xa[exp_w], xb[exp_w])
                || e !== 1'b0 || l != lat + 1) begin
                bad++;
                $display("FAIL random_txn_%0d got=%b ack=%b%b res=%h err=%b lat=%0d expected ack%0d res=%h lat=%0d",
                         i, got, w0, w1, r, e, l, exp_w, bf16_mul(xa[exp_w], xb[exp_w]), lat + 1);
            end
            pend[exp_w] = 1'b0;
            last = exp_w;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL random_traffic got %0d bad transactions expected 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_alternate();
        test_timeout();
        test_ready_wins();
        test_reset_mid();
        test_random();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
